// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side interrupt controller: FSM encoding,
// source count, PC width and the fixed-priority selector.
package cpu_pkg;

   localparam int NUM_INT = 4;
   localparam int ADDR_W  = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SERV = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      SERV = ST_SERV
   } state_t;

   // Lowest set bit wins; bit 0 (pInt1) has the highest priority.
   function automatic logic [1:0] prio_idx(input logic [NUM_INT-1:0] elig);
      logic [1:0] idx;
      idx = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (elig[i]) idx = i[1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/int_edge_det.sv
// Per-line rising-edge detector with an optional two-flop synchroniser
// in front of the history flop.
module int_edge_det #(
   parameter bit SYNC = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic rise
);

   logic sampled;
   logic prev;

   generate
      if (SYNC) begin : g_sync
         logic [1:0] sync_ff;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_ff <= '0;
            else       sync_ff <= {sync_ff[0], req};
         end
         assign sampled = sync_ff[1];
      end else begin : g_nosync
         assign sampled = req;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= sampled;
   end

   assign rise = sampled & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Four-source interrupt controller: pending capture, masking, fixed priority
// and a non-nesting request/ack/return handshake with the CPU.
module int_ctrl
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  VEC_BASE   = 10'h3C0,
   parameter logic [ADDR_W-1:0]  VEC_STRIDE = 10'd16,
   parameter logic [NUM_INT-1:0] MASK_RST   = 4'b0000,
   parameter bit                 SYNC       = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_INT-1:0] int_req,
   input  logic               mask_we,
   input  logic [NUM_INT-1:0] mask_in,
   input  logic               int_ack,
   input  logic               int_ret,
   output logic               irq,
   output logic [1:0]         int_vec,
   output logic [ADDR_W-1:0]  int_addr,
   output logic [NUM_INT-1:0] pending,
   output logic               in_service
);

   state_t             state, state_nx;
   logic [1:0]         vec_nx;
   logic [NUM_INT-1:0] mask;
   logic [NUM_INT-1:0] rise;
   logic [NUM_INT-1:0] clr;
   logic [NUM_INT-1:0] eligible;

   generate
      for (genvar g = 0; g < NUM_INT; g++) begin : g_edge
         int_edge_det #(.SYNC(SYNC)) u_edge (
            .clk   (clk),
            .reset (reset),
            .req   (int_req[g]),
            .rise  (rise[g])
         );
      end
   endgenerate

   assign eligible = pending & ~mask;

   always_comb begin
      state_nx = state;
      vec_nx   = int_vec;
      clr      = '0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               state_nx = REQ;
               vec_nx   = prio_idx(eligible);
            end
         end
         REQ: begin
            // Ack beats a concurrent mask of the latched source.
            if (int_ack) begin
               state_nx     = SERV;
               clr[int_vec] = 1'b1;
            end else if (mask[int_vec]) begin
               state_nx = IDLE;
            end
         end
         SERV: begin
            if (int_ret) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         int_vec <= '0;
      end else begin
         state   <= state_nx;
         int_vec <= vec_nx;
      end
   end

   // A fresh edge in the same cycle as the ack keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr) | rise;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        mask <= MASK_RST;
      else if (mask_we) mask <= mask_in;
   end

   assign irq        = (state == REQ);
   assign in_service = (state == SERV);
   assign int_addr   = VEC_BASE + ADDR_W'(int_vec) * VEC_STRIDE;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Four-source interrupt controller: the CPU-side receiving end of the peripheral interrupt lines (pInt1..pInt4) that the timer and other I/O blocks drive. It detects rising edges on each line, holds them as pending, masks and prioritises them, and runs a request/acknowledge/return handshake with the single-cycle CPU core. It supplies the CPU with a handler vector address and blocks new requests until the handler returns (no nesting).

## Interface
- VEC_BASE, 10'h3C0: handler address of source 0; the CPU PC is 10 bits.
- VEC_STRIDE, 10'd16: address spacing between consecutive handlers.
- MASK_RST, 4'b0000: mask value loaded at reset; 1 = masked.
- SYNC, 0: 1 inserts a 2-flop synchroniser per request line.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- int_req  in  4  request lines; bit0 = pInt1 (highest priority) … bit3 = pInt4 (lowest).
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  4  new mask value, loaded when mask_we = 1.
- int_ack  in  1  CPU accepts the interrupt (one-cycle pulse).
- int_ret  in  1  CPU executed return-from-interrupt (one-cycle pulse).
- irq  out  1  interrupt request to the CPU.
- int_vec  out  2  index of the source being requested or serviced.
- int_addr  out  10  VEC_BASE + int_vec*VEC_STRIDE, truncated to 10 bits.
- pending  out  4  pending register, for software read-back.
- in_service  out  1  a handler is active.

## Operation
- Edge detect: a source becomes pending when its (synchronised) request input is 1 and was 0 in the previous sample. Levels held high do not re-trigger.
- The pending bit stays set until that source is acknowledged. A new edge in the same cycle as its clear wins: the bit stays set.
- Eligible sources = pending & ~mask. The selected source is the lowest-index eligible bit.
- FSM states are IDLE, REQ and SERV.
  - IDLE → REQ when any source is eligible. On entry, the selected index is latched into int_vec and stays frozen while in REQ.
  - REQ with int_ack = 1: clear pending[int_vec] and go to SERV.
  - REQ with the latched source now masked and no int_ack: return to IDLE. The pending bit is kept.
  - SERV → IDLE on int_ret.
- int_ack outside REQ is ignored. int_ret outside SERV is ignored.
- Simultaneous int_ack and mask write in REQ: the ack takes effect.
- Outputs are registered or decoded from state:
  - irq = (state == REQ).
  - in_service = (state == SERV).
  - int_vec holds its value through SERV.
- mask_we updates the mask in any state. A masked source still becomes pending; it is only prevented from being selected.
- Edges arriving during SERV are recorded and become eligible after return to IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; irq = 0; in_service = 0.
  - int_vec = 0; int_addr = VEC_BASE.
  - pending = 0; mask = MASK_RST; edge/sync history = 0.
- Reset mid-handshake discards all pending and in-service state.
- Latency with SYNC = 0: int_req rises before edge N → pending set after edge N → irq = 1 after edge N+1. SYNC = 1 adds 2 cycles.
- int_ack sampled at edge M: irq = 0 and in_service = 1 after edge M. The pending bit is cleared at the same edge.
- int_ret sampled at edge K: IDLE after K. If another source is eligible, irq = 1 again after K+1, so there is a minimum one idle cycle between handlers.
- mask_we at edge M is effective for selection from edge M+1.

## Structure
- Shared package (cpu_pkg):
  - state encoding constants ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SERV = 2'd2;
  - NUM_INT = 4;
  - the 10-bit address width.
- Sub-module: int_edge_det. It holds the per-line optional synchroniser plus the rising-edge pulse, and is instantiated 4×. Priority encoder, mask, pending register and FSM live in int_ctrl.

## Test plan
- Single source: pulse int_req[2] high for 3 cycles.
  - irq = 1 two cycles after the rise, int_vec = 2, int_addr = 10'h3E0.
  - ack → pending = 0, in_service = 1.
  - ret → IDLE, no re-trigger while the line is held high.
- Priority: int_req[3] and int_req[1] rise in the same cycle.
  - First request int_vec = 1 (addr 10'h3D0).
  - After ack + ret, second request int_vec = 3 (addr 10'h3F0).
- Masking: mask = 4'b0001, then pulse int_req[0].
  - pending = 4'b0001, irq stays 0.
  - Write mask = 0 → irq = 1 after 2 cycles, int_vec = 0.
- Nesting blocked: during SERV (int_vec = 2), pulse int_req[0].
  - irq stays 0 and pending = 4'b0001.
  - int_ret → irq = 1 after 2 cycles with int_vec = 0.
- Boundary cases:
  - New edge on source 1 in the same cycle as its ack → pending[1] remains 1 and re-requests after ret.
  - Stray int_ack in IDLE and stray int_ret in REQ → no state change.
- Reset mid-operation: assert reset during SERV with pending = 4'b1010.
  - All outputs immediately reach reset values: irq = 0, in_service = 0, int_vec = 0, pending = 0.
